// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared state type and default sizes for the F1 start-light sequencer
package f1_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } seq_state_t;

  localparam int NUM_LIGHTS_DEF = 8;
  localparam int RAND_W_DEF     = 4;

endpackage

// File: rtl/tick_down_counter.sv
// rtl/tick_down_counter.sv - loadable down-counter that flags when the count reaches one
module tick_down_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Saturates at zero so a stray decrement can never wrap to a huge delay.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == W'(1));

endmodule

// File: rtl/f1_light_sequencer.sv
// rtl/f1_light_sequencer.sv - lights lamps one per tick, holds a random delay, then pulses go
module f1_light_sequencer
  import f1_pkg::*;
#(
  parameter int NUM_LIGHTS = NUM_LIGHTS_DEF,
  parameter int RAND_W     = RAND_W_DEF,
  parameter int MIN_DELAY  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic                  tick,
  input  logic [RAND_W-1:0]     rand_in,
  output logic                  lfsr_en,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic                  busy,
  output logic                  go
);

  localparam int CW = RAND_W + 1;

  seq_state_t            state_q, state_d;
  logic [NUM_LIGHTS-1:0] lights_q, lights_d;
  logic                  go_q, go_d;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_last;
  logic [CW-1:0]         cnt_load_val;

  // One bit wider than rand_in so rand_in + MIN_DELAY never wraps.
  assign cnt_load_val = {1'b0, rand_in} + CW'(MIN_DELAY);
  assign cnt_dec      = tick && (state_q == HOLD);

  tick_down_counter #(
    .W(CW)
  ) u_delay_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .dec     (cnt_dec),
    .last    (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    lights_d = lights_q;
    go_d     = 1'b0;
    cnt_load = 1'b0;
    case (state_q)
      IDLE: begin
        lights_d = '0;
        if (trigger) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (tick) begin
          lights_d = {lights_q[NUM_LIGHTS-2:0], 1'b1};
          // The lamp being lit now is the last one: capture the random hold length.
          if (&lights_q[NUM_LIGHTS-2:0]) begin
            cnt_load = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick && cnt_last) begin
          lights_d = '0;
          go_d     = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        lights_d = '0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lights_q <= '0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      lights_q <= lights_d;
      go_q     <= go_d;
    end
  end

  assign lights  = lights_q;
  assign go      = go_q;
  assign busy    = (state_q != IDLE);
  assign lfsr_en = (state_q != HOLD);

endmodule
